// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared types and constants for the core memory arbiter
package core_mem_pkg;

    typedef enum logic {OWN_INSTR, OWN_LSU} owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
        logic   we;
    } resp_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/core_mem_resp_pipe.sv
// core_mem_resp_pipe: fixed-latency response pipeline routing data back to the owning requester
module core_mem_resp_pipe
    import core_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  resp_t       entry_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o
);

    resp_t [MEM_LATENCY-1:0] stage;
    resp_t                   head;
    logic  [31:0]            rdata;

    // shift grant records so each one surfaces exactly MEM_LATENCY cycles later
    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= entry_i;
            for (int i = 1; i < MEM_LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    // in-flight responses are dropped while reset is held; data only for read hits
    always_comb begin
        head           = stage[MEM_LATENCY-1];
        head.valid     = head.valid && !rst;
        rdata          = (head.valid && !head.err && !head.we) ? mem_rdata_i : '0;
        instr_rvalid_o = head.valid && head.owner == OWN_INSTR;
        lsu_rvalid_o   = head.valid && head.owner == OWN_LSU;
        instr_rdata_o  = instr_rvalid_o ? rdata : '0;
        lsu_rdata_o    = lsu_rvalid_o ? rdata : '0;
        instr_err_o    = instr_rvalid_o && head.err;
        lsu_err_o      = lsu_rvalid_o && head.err;
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port SRAM between the fetch and LSU ports
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int          MEM_ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          MEM_LATENCY    = 1,
    parameter bit          LSU_PRIO       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    input  logic                      lsu_req_i,
    output logic                      lsu_gnt_o,
    input  logic                      lsu_we_i,
    input  logic [3:0]                lsu_be_i,
    input  logic [31:0]               lsu_addr_i,
    input  logic [31:0]               lsu_wdata_i,
    output logic                      lsu_rvalid_o,
    output logic [31:0]               lsu_rdata_o,
    output logic                      lsu_err_o,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i
);

    owner_e      rr_last;
    logic        lsu_win;
    logic        gnt;
    logic        hit;
    logic [31:0] addr;
    resp_t       entry;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    // arbitrate, window-check the winner and drive the SRAM; misses never reach memory
    always_comb begin
        lsu_win     = lsu_req_i && (!instr_req_i || LSU_PRIO || rr_last == OWN_INSTR);
        instr_gnt_o = !rst && instr_req_i && !lsu_win;
        lsu_gnt_o   = !rst && lsu_win;
        gnt         = instr_gnt_o || lsu_gnt_o;
        addr        = lsu_gnt_o ? lsu_addr_i : instr_addr_i;
        hit         = addr[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2];
        mem_req_o   = gnt && hit;
        mem_addr_o  = mem_req_o ? addr[MEM_ADDR_WIDTH+1:2] : '0;
        mem_we_o    = mem_req_o && lsu_gnt_o && lsu_we_i;
        mem_be_o    = !mem_req_o ? '0 : lsu_gnt_o ? lsu_be_i : BE_ALL;
        mem_wdata_o = (mem_req_o && lsu_gnt_o) ? lsu_wdata_i : '0;
        entry       = '{valid: gnt, owner: lsu_gnt_o ? OWN_LSU : OWN_INSTR,
                        err: gnt && !hit, we: lsu_gnt_o && lsu_we_i};
    end

    // remember the last winner so the next tie goes to the other port
    always_ff @(posedge clk) begin
        if (rst) rr_last <= OWN_LSU;
        else if (gnt) rr_last <= lsu_gnt_o ? OWN_LSU : OWN_INSTR;
    end

    core_mem_resp_pipe #(.MEM_LATENCY(MEM_LATENCY)) u_resp (
        .clk           (clk),
        .rst           (rst),
        .entry_i       (entry),
        .mem_rdata_i   (mem_rdata_i),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .lsu_rvalid_o  (lsu_rvalid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_err_o     (lsu_err_o)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed vector bench over three parameterisations of the arbiter
module tb_core_mem_arbiter;

    typedef struct packed {
        logic        ig;
        logic        lg;
        logic        mreq;
        logic [12:0] madr;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        logic        irv;
        logic [31:0] ird;
        logic        ierr;
        logic        lrv;
        logic [31:0] lrd;
        logic        lerr;
    } out_t;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        lreq;
        logic        lwe;
        logic [3:0]  lbe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic [31:0] mr;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, lreq, lwe;
    logic [3:0]  lbe;
    logic [31:0] iaddr, laddr, lwdata, mrdata;

    logic        ig[3], lg[3], irv[3], ierr[3], lrv[3], lerr[3], mreq[3], mwe[3];
    logic [31:0] ird[3], lrd[3], mwd[3];
    logic [12:0] madr[3];
    logic [3:0]  mbe[3];

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        core_mem_arbiter #(
            .MEM_LATENCY(g == 2 ? 2 : 1),
            .LSU_PRIO   (g == 1 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .instr_req_i   (ireq),
            .instr_gnt_o   (ig[g]),
            .instr_addr_i  (iaddr),
            .instr_rvalid_o(irv[g]),
            .instr_rdata_o (ird[g]),
            .instr_err_o   (ierr[g]),
            .lsu_req_i     (lreq),
            .lsu_gnt_o     (lg[g]),
            .lsu_we_i      (lwe),
            .lsu_be_i      (lbe),
            .lsu_addr_i    (laddr),
            .lsu_wdata_i   (lwdata),
            .lsu_rvalid_o  (lrv[g]),
            .lsu_rdata_o   (lrd[g]),
            .lsu_err_o     (lerr[g]),
            .mem_req_o     (mreq[g]),
            .mem_addr_o    (madr[g]),
            .mem_we_o      (mwe[g]),
            .mem_be_o      (mbe[g]),
            .mem_wdata_o   (mwd[g]),
            .mem_rdata_i   (mrdata)
        );
    end

    function automatic out_t ox(logic g_i, logic g_l, logic mr, logic [12:0] ma, logic mw,
                                logic [3:0] mb, logic [31:0] wd, logic rv_i, logic [31:0] rd_i,
                                logic e_i, logic rv_l, logic [31:0] rd_l, logic e_l);
        return '{g_i, g_l, mr, ma, mw, mb, wd, rv_i, rd_i, e_i, rv_l, rd_l, e_l};
    endfunction

    function automatic out_t obs(int k);
        return '{ig[k], lg[k], mreq[k], madr[k], mwe[k], mbe[k], mwd[k],
                 irv[k], ird[k], ierr[k], lrv[k], lrd[k], lerr[k]};
    endfunction

    task automatic drive(logic i_r, logic [31:0] i_a, logic l_r, logic l_w, logic [3:0] l_b,
                         logic [31:0] l_a, logic [31:0] l_d, logic [31:0] m_r);
        ireq = i_r; iaddr = i_a; lreq = l_r; lwe = l_w; lbe = l_b;
        laddr = l_a; lwdata = l_d; mrdata = m_r;
    endtask

    task automatic add(logic i_r, logic [31:0] i_a, logic l_r, logic l_w, logic [3:0] l_b,
                       logic [31:0] l_a, logic [31:0] l_d, logic [31:0] m_r, out_t e);
        vq.push_back('{i_r, i_a, l_r, l_w, l_b, l_a, l_d, m_r, e});
    endtask

    task automatic check(string name, int k, out_t e);
        out_t a;
        a = obs(k);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    localparam logic [31:0] LA = 32'h1000_0100;

    initial begin
        out_t z;
        z = ox(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("reset", k, z);
        step();
        rst = 1'b0;

        add(0, 0, 0, 0, 0, 0, 0, 0, z);
        add(1, 32'h1000_0010, 1, 0, 4'hF, LA, 0, 0,
            ox(1, 0, 1, 13'h4, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0));
        add(1, 32'h1000_0010, 1, 0, 4'hF, LA, 0, 32'h1111_1111,
            ox(0, 1, 1, 13'h40, 0, 4'hF, 0, 1, 32'h1111_1111, 0, 0, 0, 0));
        add(1, 32'h1000_0010, 1, 0, 4'hF, LA, 0, 32'h2222_2222,
            ox(1, 0, 1, 13'h4, 0, 4'hF, 0, 0, 0, 0, 1, 32'h2222_2222, 0));
        add(1, 32'h1000_0010, 1, 0, 4'hF, LA, 0, 32'h3333_3333,
            ox(0, 1, 1, 13'h40, 0, 4'hF, 0, 1, 32'h3333_3333, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, 0, 32'h4444_4444,
            ox(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4444_4444, 0));
        add(0, 0, 1, 1, 4'b0011, 32'h2000_0000, 32'h1234_5678, 0,
            ox(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, 0, 32'h5555_5555,
            ox(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        add(0, 0, 1, 1, 4'b0011, 32'h1000_0008, 32'hA5A5_A5A5, 0,
            ox(0, 1, 1, 13'h2, 1, 4'b0011, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0));
        add(1, 32'h0000_0010, 0, 0, 0, 0, 0, 32'h6666_6666,
            ox(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(1, 32'h1000_7FFC, 0, 0, 0, 0, 0, 32'h7777_7777,
            ox(1, 0, 1, 13'h1FFF, 0, 4'hF, 0, 1, 0, 1, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, 0, 32'h8888_8888,
            ox(0, 0, 0, 0, 0, 0, 0, 1, 32'h8888_8888, 0, 0, 0, 0));
        add(1, 32'h1000_8000, 0, 0, 0, 0, 0, 0,
            ox(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, 0, 32'h9999_9999,
            ox(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

        foreach (vq[n]) begin
            drive(vq[n].ireq, vq[n].iaddr, vq[n].lreq, vq[n].lwe, vq[n].lbe,
                  vq[n].laddr, vq[n].lwdata, vq[n].mr);
            @(negedge clk);
            check($sformatf("vec%0d", n), 0, vq[n].exp);
            step();
        end

        do_reset();
        for (int c = 0; c < 5; c++) begin
            logic [31:0] m;
            m = 32'hB000_0000 + 32'(c);
            drive(1, 32'h1000_0010, c < 3, 0, 4'hF, LA, 0, m);
            @(negedge clk);
            check($sformatf("prio_c%0d", c), 1,
                  c < 3 ? ox(0, 1, 1, 13'h40, 0, 4'hF, 0, 0, 0, 0, c > 0, c > 0 ? m : 0, 0)
                        : ox(1, 0, 1, 13'h4, 0, 4'hF, 0, c == 4, c == 4 ? m : 0, 0, c == 3, c == 3 ? m : 0, 0));
            step();
        end

        do_reset();
        for (int c = 0; c < 5; c++) begin
            logic [31:0] m;
            m = 32'hD000_0000 + 32'(c);
            drive(c < 3, 32'h1000_0010 + 32'(4 * c), 0, 0, 0, 0, 0, m);
            @(negedge clk);
            check($sformatf("lat2_c%0d", c), 2,
                  ox(c < 3, 0, c < 3, c < 3 ? 13'(4 + c) : 13'h0, 0, c < 3 ? 4'hF : 4'h0, 0,
                     c >= 2, c >= 2 ? m : 0, 0, 0, 0, 0));
            step();
        end

        do_reset();
        drive(1, 32'h1000_0010, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_grant", 0, ox(1, 0, 1, 13'h4, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0));
        step();
        rst = 1'b1;
        drive(1, 32'h1000_0010, 1, 0, 4'hF, LA, 0, 32'hABCD_0123);
        @(negedge clk);
        check("rst_held", 0, z);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'hABCD_0123);
        @(negedge clk);
        check("rst_flushed", 0, z);
        step();
        drive(1, 32'h1000_0010, 1, 0, 4'hF, LA, 0, 0);
        @(negedge clk);
        check("rst_tie", 0, ox(1, 0, 1, 13'h4, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
